jtag_tap_param: RTL and testbench
=================================

// Module: jtag_tap_param
// PURPOSE
//  Parametrised IEEE 1149.1 TAP controller. Integrates the 16-state TAP FSM, an IR of configurable
//  width, built-in IDCODE and BYPASS data registers, and NUM_CHAINS external data-chain selects.
//  Sits between the chip JTAG pins and the debug-module DTM chains (DTMCS, DMI, ...).
// PARAMETERS
//  IR_WIDTH      5                 instruction register width, >=2
//  IDCODE_VALUE  32'h0000_0001     IDCODE capture value; bit0 forced to 1 on capture
//  IDCODE_INSTR  1                 instruction selecting IDCODE; active instruction after reset/TLR
//  NUM_CHAINS    2                 external data chains, >=1
//  CHAIN_INSTRS  {5'h11,5'h10}     packed NUM_CHAINS*IR_WIDTH; chain i opcode = bits [i*IR_WIDTH +: IR_WIDTH]
// PORTS
//  clock            in   1                  TCK
//  reset            in   1                  synchronous, active-high; sampled on rising edge of clock
//  jtag_tms         in   1                  TMS, sampled on rising edge
//  jtag_tdi         in   1                  TDI, sampled on rising edge
//  jtag_tdo         out  1                  TDO, changes on falling edge
//  jtag_tdo_en      out  1                  TDO driver enable, changes on falling edge
//  chain_sel        out  NUM_CHAINS         one-hot: chain whose opcode is active; 0 otherwise
//  chain_tdo        in   NUM_CHAINS         serial out of each external chain
//  chain_tdi        out  1                  = jtag_tdi
//  chain_capture    out  1                  state==CaptureDR && |chain_sel
//  chain_shift      out  1                  state==ShiftDR && |chain_sel
//  chain_update     out  1                  state==UpdateDR && |chain_sel
//  instruction      out  IR_WIDTH           active instruction
//  tap_in_tlr       out  1                  state==TestLogicReset
// BEHAVIOUR
//  - Reset, rising edge: state=TLR(4'hF), instruction=IDCODE_INSTR, ir_shift=0, bypass=0, idcode_shift=0.
//    Falling edge: jtag_tdo=0, jtag_tdo_en=0. Reset mid-shift abandons the shift; instruction is not updated.
//  - State encoding (4 bit): TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0,
//    UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
//  - Standard 1149.1 transitions on TMS at rising edge. Five TMS=1 cycles reach TLR from any state.
//  - The action for state S takes effect at the rising edge that leaves S.
//  - IR:
//    - CapIR: ir_shift <= {0..., 2'b01}.
//    - ShIR: ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]}.
//    - UpdIR: instruction <= ir_shift.
//    - In TLR, instruction <= IDCODE_INSTR every cycle.
//  - Decode of instruction, in priority order:
//    - == IDCODE_INSTR -> IDCODE register.
//    - Else the lowest i with CHAIN_INSTRS[i] == instruction -> chain i; chain_sel[i]=1.
//    - Else -> BYPASS. This includes all-ones and every unmapped opcode.
//  - DR:
//    - CapDR: bypass <= 0; idcode_shift <= IDCODE_VALUE | 1.
//    - ShDR: right-shift the selected internal register, tdi entering the MSB.
//    - External chains shift themselves, using chain_shift and chain_tdi.
//  - TDO, falling edge:
//    - ShIR: tdo = ir_shift[0].
//    - ShDR: tdo = selected source (idcode_shift[0], bypass, or chain_tdo[i]).
//    - tdo_en = 1 in ShIR or ShDR; otherwise tdo_en = 0 and tdo holds its value.
//  - chain_* strobes, tap_in_tlr and chain_sel are combinational from the registered state and instruction.
//  - Latency: a new IR value is visible on instruction and chain_sel in the cycle after UpdIR.
//    BYPASS adds exactly 1 bit of delay.
// TESTING
//  - Reset, then TMS=0,1,0,0 reaches ShDR; shift 32 bits TDI=0 -> TDO LSB-first = IDCODE_VALUE|1 (e.g. 32'h0000_0001).
//  - Load IR=5'h1F then shift DR with TDI=1,0,1,1 -> TDO=0,1,0,1 (1-bit bypass, capture 0); chain_sel=0.
//  - Load IR=5'h10 -> chain_sel=2'b01. In DR scan, capture/shift/update pulse once per state;
//    TDO follows chain_tdo[0] on falling edges.
//  - Set CHAIN_INSTRS both =5'h10, load 5'h10 -> chain_sel=2'b01 (lowest index wins). Set a chain
//    opcode equal to IDCODE_INSTR -> IDCODE selected.
//  - In ShIR shift 5'h11; during the shift TDO shows the capture pattern 1,0,0,0,0. Then TMS=1 x5
//    before UpdIR -> TLR reached, instruction=IDCODE_INSTR (not 5'h11).
//  - Assert reset during ShDR mid-IDCODE -> next cycle tap_in_tlr=1, tdo_en=0, instruction=IDCODE_INSTR.

Source files
------------

// File: rtl/jtag_tap_param.sv
// -----------------------------------------------------------------------------
// jtag_tap_param
//
// Parametrised IEEE 1149.1 TAP controller. It contains:
//   - the 16-state TAP FSM, advanced on the rising edge of TCK;
//   - an instruction register of IR_WIDTH bits;
//   - the built-in IDCODE and BYPASS data registers;
//   - select and strobe outputs for NUM_CHAINS external data chains, such as
//     the DTMCS and DMI chains of a debug module.
//
// The TDO pin and its driver enable are updated on the falling edge of TCK.
//
// Ports
//   clock          in   TCK. All rising-edge and falling-edge logic uses it.
//   reset          in   synchronous, active high. Sampled on the rising edge
//                       for the TAP state, and on the falling edge for TDO.
//   jtag_tms       in   TMS, sampled on the rising edge.
//   jtag_tdi       in   TDI, sampled on the rising edge.
//   jtag_tdo       out  TDO. Holds its last value while not shifting.
//   jtag_tdo_en    out  TDO driver enable. High only in Shift-IR and Shift-DR.
//   chain_sel      out  one-hot select of the external chain that the active
//                       instruction addresses. All zero if none is addressed.
//   chain_tdo      in   serial output of each external chain.
//   chain_tdi      out  serial input to the external chains (equals jtag_tdi).
//   chain_capture  out  high in Capture-DR when an external chain is selected.
//   chain_shift    out  high in Shift-DR when an external chain is selected.
//   chain_update   out  high in Update-DR when an external chain is selected.
//   instruction    out  the active instruction.
//   tap_in_tlr     out  high while the FSM is in Test-Logic-Reset.
// -----------------------------------------------------------------------------
module jtag_tap_param #(
    parameter int                                IR_WIDTH     = 5,
    parameter logic [31:0]                       IDCODE_VALUE = 32'h0000_0001,
    parameter int                                IDCODE_INSTR = 1,
    parameter int                                NUM_CHAINS   = 2,
    parameter logic [NUM_CHAINS*IR_WIDTH-1:0]    CHAIN_INSTRS = {5'h11, 5'h10}
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  jtag_tms,
    input  logic                  jtag_tdi,
    output logic                  jtag_tdo,
    output logic                  jtag_tdo_en,
    output logic [NUM_CHAINS-1:0] chain_sel,
    input  logic [NUM_CHAINS-1:0] chain_tdo,
    output logic                  chain_tdi,
    output logic                  chain_capture,
    output logic                  chain_shift,
    output logic                  chain_update,
    output logic [IR_WIDTH-1:0]   instruction,
    output logic                  tap_in_tlr
);

    // The encoding matches the state numbering commonly used for the 1149.1
    // TAP, so a state can be read directly off a debug probe.
    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] IDCODE_OP   = IR_WIDTH'(IDCODE_INSTR);
    // Value loaded into the IR in Capture-IR: binary ...0001.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE  = IR_WIDTH'(1);
    localparam logic [31:0]         IDCODE_CAPT = IDCODE_VALUE | 32'h1;

    // -------------------------------------------------------------------------
    // Registers on the rising edge, with their next-state values
    // -------------------------------------------------------------------------
    tap_state_e          state_q,        state_d;
    logic [IR_WIDTH-1:0] instr_q,        instr_d;
    logic [IR_WIDTH-1:0] ir_shift_q,     ir_shift_d;
    logic                bypass_q,       bypass_d;
    logic [31:0]         idcode_shift_q, idcode_shift_d;

    // Registers on the falling edge
    logic                tdo_q,          tdo_d;
    logic                tdo_en_q,       tdo_en_d;

    // -------------------------------------------------------------------------
    // Instruction decode
    // -------------------------------------------------------------------------
    logic                  sel_idcode;
    logic                  sel_bypass;
    logic [NUM_CHAINS-1:0] chain_hit;
    logic [NUM_CHAINS-1:0] chain_sel_w;
    logic                  dr_tdo;

    assign sel_idcode = (instr_q == IDCODE_OP);

    generate
        for (genvar gi = 0; gi < NUM_CHAINS; gi++) begin : g_chain_match
            assign chain_hit[gi] = (instr_q == CHAIN_INSTRS[gi*IR_WIDTH +: IR_WIDTH]);
        end
    endgenerate

    // Several chains may share an opcode. In that case the lowest index wins.
    // The expression x & -x keeps only the least-significant set bit of x.
    // The IDCODE opcode outranks every chain.
    always_comb begin
        chain_sel_w = '0;
        if (!sel_idcode) begin
            chain_sel_w = chain_hit & (~chain_hit + NUM_CHAINS'(1));
        end
    end

    // Anything that is neither IDCODE nor a mapped chain selects BYPASS.
    // This includes the all-ones opcode.
    assign sel_bypass = !sel_idcode && (chain_sel_w == '0);

    // Serial source shown on TDO during Shift-DR.
    always_comb begin
        dr_tdo = bypass_q;
        if (sel_idcode) begin
            dr_tdo = idcode_shift_q[0];
        end else if (!sel_bypass) begin
            dr_tdo = |(chain_sel_w & chain_tdo);
        end
    end

    // -------------------------------------------------------------------------
    // TAP state transitions
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:      state_d = jtag_tms ? TLR      : RTI;
            RTI:      state_d = jtag_tms ? SEL_DR   : RTI;
            SEL_DR:   state_d = jtag_tms ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = jtag_tms ? EX1_DR   : SH_DR;
            SH_DR:    state_d = jtag_tms ? EX1_DR   : SH_DR;
            EX1_DR:   state_d = jtag_tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = jtag_tms ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_d = jtag_tms ? UPD_DR   : SH_DR;
            UPD_DR:   state_d = jtag_tms ? SEL_DR   : RTI;
            SEL_IR:   state_d = jtag_tms ? TLR      : CAP_IR;
            CAP_IR:   state_d = jtag_tms ? EX1_IR   : SH_IR;
            SH_IR:    state_d = jtag_tms ? EX1_IR   : SH_IR;
            EX1_IR:   state_d = jtag_tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = jtag_tms ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_d = jtag_tms ? UPD_IR   : SH_IR;
            UPD_IR:   state_d = jtag_tms ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    // -------------------------------------------------------------------------
    // Register actions. The action for a state is decided from the current
    // state, so it takes effect on the edge that leaves that state.
    // -------------------------------------------------------------------------
    always_comb begin
        instr_d        = instr_q;
        ir_shift_d     = ir_shift_q;
        bypass_d       = bypass_q;
        idcode_shift_d = idcode_shift_q;
        case (state_q)
            TLR: begin
                instr_d = IDCODE_OP;
            end
            CAP_IR: begin
                ir_shift_d = IR_CAPTURE;
            end
            SH_IR: begin
                ir_shift_d = {jtag_tdi, ir_shift_q[IR_WIDTH-1:1]};
            end
            UPD_IR: begin
                instr_d = ir_shift_q;
            end
            CAP_DR: begin
                bypass_d       = 1'b0;
                idcode_shift_d = IDCODE_CAPT;
            end
            SH_DR: begin
                // External chains shift themselves off chain_shift and
                // chain_tdi. Only the internal registers are handled here.
                if (sel_idcode) begin
                    idcode_shift_d = {jtag_tdi, idcode_shift_q[31:1]};
                end else if (sel_bypass) begin
                    bypass_d = jtag_tdi;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // A shift that is in progress is abandoned. The instruction
            // returns to IDCODE and is never loaded from ir_shift.
            state_q        <= TLR;
            instr_q        <= IDCODE_OP;
            ir_shift_q     <= '0;
            bypass_q       <= 1'b0;
            idcode_shift_q <= '0;
        end else begin
            state_q        <= state_d;
            instr_q        <= instr_d;
            ir_shift_q     <= ir_shift_d;
            bypass_q       <= bypass_d;
            idcode_shift_q <= idcode_shift_d;
        end
    end

    // -------------------------------------------------------------------------
    // TDO on the falling edge. A shift register's bit 0 is presented half a
    // cycle before the rising edge that shifts it out. When not shifting, TDO
    // keeps its last value and only the enable is dropped.
    // -------------------------------------------------------------------------
    always_comb begin
        tdo_d    = tdo_q;
        tdo_en_d = 1'b0;
        case (state_q)
            SH_IR: begin
                tdo_d    = ir_shift_q[0];
                tdo_en_d = 1'b1;
            end
            SH_DR: begin
                tdo_d    = dr_tdo;
                tdo_en_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign jtag_tdo      = tdo_q;
    assign jtag_tdo_en   = tdo_en_q;
    assign chain_sel     = chain_sel_w;
    assign chain_tdi     = jtag_tdi;
    assign chain_capture = (state_q == CAP_DR) && (|chain_sel_w);
    assign chain_shift   = (state_q == SH_DR)  && (|chain_sel_w);
    assign chain_update  = (state_q == UPD_DR) && (|chain_sel_w);
    assign instruction   = instr_q;
    assign tap_in_tlr    = (state_q == TLR);

endmodule

// File: tb/tb_jtag_tap_param.sv
// -----------------------------------------------------------------------------
// tb_jtag_tap_param
//
// Directed testbench for jtag_tap_param. Three instances share TCK, TMS and
// TDI:
//   dut      chain opcodes {11,10}; a non-trivial IDCODE value.
//   dut_dup  both chain opcodes are 10, to check that the lowest index wins.
//   dut_idc  chain 1 opcode equals IDCODE_INSTR, to check that IDCODE wins.
// Expected values are worked out by hand from the TAP behaviour.
// -----------------------------------------------------------------------------
module tb_jtag_tap_param;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       jtag_tms = 1'b1;
    logic       jtag_tdi = 1'b0;
    logic [1:0] chain_tdo_r = 2'b00;

    // Outputs of the main instance
    logic       jtag_tdo, jtag_tdo_en, chain_tdi;
    logic       chain_capture, chain_shift, chain_update, tap_in_tlr;
    logic [1:0] chain_sel;
    logic [4:0] instruction;

    // Outputs of the duplicate-opcode instance
    logic       d_tdo, d_tdo_en, d_chain_tdi, d_cap, d_sh, d_upd, d_tlr;
    logic [1:0] d_chain_sel;
    logic [4:0] d_instr;

    // Outputs of the IDCODE-collision instance
    logic       i_tdo, i_tdo_en, i_chain_tdi, i_cap, i_sh, i_upd, i_tlr;
    logic [1:0] i_chain_sel;
    logic [4:0] i_instr;

    localparam logic [31:0] IDV = 32'hABCD_E456;

    jtag_tap_param #(.IDCODE_VALUE(IDV)) dut (
        .clock(clock), .reset(reset), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
        .jtag_tdo(jtag_tdo), .jtag_tdo_en(jtag_tdo_en), .chain_sel(chain_sel),
        .chain_tdo(chain_tdo_r), .chain_tdi(chain_tdi), .chain_capture(chain_capture),
        .chain_shift(chain_shift), .chain_update(chain_update),
        .instruction(instruction), .tap_in_tlr(tap_in_tlr)
    );

    jtag_tap_param #(.CHAIN_INSTRS({5'h10, 5'h10})) dut_dup (
        .clock(clock), .reset(reset), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
        .jtag_tdo(d_tdo), .jtag_tdo_en(d_tdo_en), .chain_sel(d_chain_sel),
        .chain_tdo(chain_tdo_r), .chain_tdi(d_chain_tdi), .chain_capture(d_cap),
        .chain_shift(d_sh), .chain_update(d_upd),
        .instruction(d_instr), .tap_in_tlr(d_tlr)
    );

    jtag_tap_param #(.CHAIN_INSTRS({5'h01, 5'h12})) dut_idc (
        .clock(clock), .reset(reset), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
        .jtag_tdo(i_tdo), .jtag_tdo_en(i_tdo_en), .chain_sel(i_chain_sel),
        .chain_tdo(chain_tdo_r), .chain_tdi(i_chain_tdi), .chain_capture(i_cap),
        .chain_shift(i_sh), .chain_update(i_upd),
        .instruction(i_instr), .tap_in_tlr(i_tlr)
    );

    always #5 clock = ~clock;

    // Count the chain strobes of the main instance, once per TCK cycle.
    int cap_cnt = 0;
    int sh_cnt  = 0;
    int upd_cnt = 0;
    always @(negedge clock) begin
        if (chain_capture) cap_cnt++;
        if (chain_shift)   sh_cnt++;
        if (chain_update)  upd_cnt++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // One TCK cycle. Returns 1 ns after the following falling edge, so that
    // both the rising-edge and the falling-edge outputs are settled.
    task automatic step(input logic tms, input logic tdi);
        jtag_tms = tms;
        jtag_tdi = tdi;
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    // Run-Test/Idle -> load a 5-bit instruction -> Run-Test/Idle.
    // cap returns the TDO bits seen while shifting, LSB first.
    task automatic load_ir(input logic [4:0] v, output logic [4:0] cap);
        step(1'b1, 1'b0);  // Select-DR
        step(1'b1, 1'b0);  // Select-IR
        step(1'b0, 1'b0);  // Capture-IR
        step(1'b0, 1'b0);  // Shift-IR
        cap = '0;
        for (int i = 0; i < 5; i++) begin
            cap[i] = jtag_tdo;
            step(i == 4, v[i]);
        end
        step(1'b1, 1'b0);  // Update-IR
        step(1'b0, 1'b0);  // Run-Test/Idle; the new instruction is active
    endtask

    // Run-Test/Idle -> DR scan of n bits -> Run-Test/Idle.
    // chain_tdo[0] carries cpat and chain_tdo[1] carries its inverse.
    task automatic scan_dr(input int n, input logic [31:0] din, input logic [31:0] cpat,
                           output logic [31:0] dout);
        logic nb;
        step(1'b1, 1'b0);  // Select-DR
        step(1'b0, 1'b0);  // Capture-DR
        chain_tdo_r = {~cpat[0], cpat[0]};
        step(1'b0, 1'b0);  // Shift-DR
        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = jtag_tdo;
            nb = 1'b0;
            if (i + 1 < n) nb = cpat[i + 1];
            chain_tdo_r = {~nb, nb};
            step(i == n - 1, din[i]);
        end
        step(1'b1, 1'b0);  // Update-DR
        step(1'b0, 1'b0);  // Run-Test/Idle
    endtask

    initial begin
        logic [4:0]  cb;
        logic [31:0] dout;
        int c0, s0, u0;

        // ---------------- Reset state ----------------
        reset = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("rst_tlr",    32'(tap_in_tlr),  32'd1);
        check("rst_instr",  32'(instruction), 32'h01);
        check("rst_tdo_en", 32'(jtag_tdo_en), 32'd0);
        check("rst_tdo",    32'(jtag_tdo),    32'd0);
        check("rst_sel",    32'(chain_sel),   32'd0);
        reset = 1'b0;
        step(1'b0, 1'b0);  // Run-Test/Idle
        check("rti_not_tlr", 32'(tap_in_tlr), 32'd0);

        // ---------------- IDCODE scan ----------------
        scan_dr(32, 32'h0, 32'h0, dout);
        check("idcode", dout, IDV | 32'h1);

        // ---------------- BYPASS via all-ones ----------------
        load_ir(5'h1F, cb);
        check("ir_capture", 32'(cb), 32'h01);
        check("instr_1f", 32'(instruction), 32'h1F);
        check("sel_1f", 32'(chain_sel), 32'd0);
        scan_dr(4, 32'b1101, 32'h0, dout);
        check("bypass", dout, 32'b1010);

        // ---------------- Chain 0 ----------------
        load_ir(5'h10, cb);
        check("sel_10", 32'(chain_sel), 32'b01);
        check("dup_sel_10", 32'(d_chain_sel), 32'b01);
        check("idc_sel_10", 32'(i_chain_sel), 32'b00);
        jtag_tdi = 1'b1;
        #1;
        check("chain_tdi", 32'(chain_tdi), 32'd1);
        jtag_tdi = 1'b0;
        c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
        scan_dr(8, 32'h0, 32'hB4, dout);
        check("chain0_tdo", dout, 32'hB4);
        check("cap_pulses", 32'(cap_cnt - c0), 32'd1);
        check("sh_pulses",  32'(sh_cnt - s0),  32'd8);
        check("upd_pulses", 32'(upd_cnt - u0), 32'd1);

        // ---------------- Chain 1 ----------------
        load_ir(5'h11, cb);
        check("sel_11", 32'(chain_sel), 32'b10);
        check("dup_sel_11", 32'(d_chain_sel), 32'b00);
        scan_dr(6, 32'h0, 32'b011010, dout);
        check("chain1_tdo", dout, 32'b100101);

        // ---------------- IDCODE opcode outranks a chain ----------------
        load_ir(5'h01, cb);
        check("idc_sel_01", 32'(i_chain_sel), 32'b00);
        check("instr_01", 32'(instruction), 32'h01);
        load_ir(5'h12, cb);
        check("idc_sel_12", 32'(i_chain_sel), 32'b01);
        check("sel_12", 32'(chain_sel), 32'b00);

        // ---------------- Shift-IR, then five TMS=1 cycles to TLR ----------------
        step(1'b1, 1'b0);  // Select-DR
        step(1'b1, 1'b0);  // Select-IR
        step(1'b0, 1'b0);  // Capture-IR
        step(1'b0, 1'b0);  // Shift-IR
        cb = '0;
        for (int i = 0; i < 5; i++) begin
            cb[i] = jtag_tdo;
            step(i == 4, (i == 0) || (i == 4));  // shifts in 5'h11
        end
        check("abort_capture", 32'(cb), 32'h01);
        step(1'b1, 1'b0);  // Update-IR
        step(1'b1, 1'b0);  // Select-DR
        check("abort_mid_instr", 32'(instruction), 32'h11);
        step(1'b1, 1'b0);  // Select-IR
        step(1'b1, 1'b0);  // Test-Logic-Reset
        check("abort_tlr", 32'(tap_in_tlr), 32'd1);
        step(1'b1, 1'b0);
        check("abort_instr", 32'(instruction), 32'h01);
        step(1'b0, 1'b0);  // Run-Test/Idle

        // ---------------- Reset during a bypass shift ----------------
        load_ir(5'h1F, cb);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);  // Shift-DR
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        check("byp_mid_en", 32'(jtag_tdo_en), 32'd1);
        check("byp_mid_tdo", 32'(jtag_tdo), 32'd1);
        reset = 1'b1;
        step(1'b0, 1'b0);
        check("rst_byp_tlr",   32'(tap_in_tlr),  32'd1);
        check("rst_byp_instr", 32'(instruction), 32'h01);
        check("rst_byp_en",    32'(jtag_tdo_en), 32'd0);
        check("rst_byp_tdo",   32'(jtag_tdo),    32'd0);
        reset = 1'b0;
        step(1'b0, 1'b0);  // Run-Test/Idle

        // ---------------- Reset during an IDCODE shift ----------------
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);  // Shift-DR
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        check("idc_mid_en", 32'(jtag_tdo_en), 32'd1);
        reset = 1'b1;
        step(1'b0, 1'b0);
        check("rst_idc_tlr",   32'(tap_in_tlr),  32'd1);
        check("rst_idc_en",    32'(jtag_tdo_en), 32'd0);
        check("rst_idc_instr", 32'(instruction), 32'h01);
        reset = 1'b0;
        step(1'b0, 1'b0);
        scan_dr(32, 32'hFFFF_FFFF, 32'h0, dout);
        check("idcode_again", dout, IDV | 32'h1);

        // ---------------- Five TMS=1 cycles from Shift-DR ----------------
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);  // Shift-DR
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("shdr_to_tlr", 32'(tap_in_tlr), 32'd1);
        check("shdr_tlr_en", 32'(jtag_tdo_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
